cordic_rotation_iter: RTL
=========================

// Module: cordic_rotation_iter
// PURPOSE
//  Iterative CORDIC engine in rotation mode: rotates vector (x_in, y_in) by angle z_in, driving the residual angle to zero.
//  Complements the vectoring-mode datapath: vectoring extracts magnitude/angle, this block rebuilds x/y from an angle.
//  Performs one micro-rotation per clock with a start/done handshake. Outputs carry the CORDIC gain K~1.6468 (no compensation).
// PARAMETERS
//  WORD_LENGTH   16  signed width of x/y/z ports (two's complement)
//  SHIFT_LENGTH  5   width of iteration index / shift amount
//  ITERATIONS    12  micro-rotations per operation; must be <= 2**SHIFT_LENGTH and <= 12 (atan table depth)
// PORTS
//  clk      in   1    rising-edge clock
//  rst      in   1    synchronous, active-high reset
//  start    in   1    request; sampled only in IDLE
//  x_in     in   W    signed initial x
//  y_in     in   W    signed initial y
//  z_in     in   W    signed angle, Q2.13 radians, valid range [-12868, +12868] (+-pi/2)
//  busy     out  1    high in RUN and DONE
//  done     out  1    one-cycle pulse; x_out/y_out valid from this cycle
//  x_out    out  W    signed rotated x (gain included, saturated)
//  y_out    out  W    signed rotated y (gain included, saturated)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, x_out=0, y_out=0, internal regs and counter = 0.
//  FSM IDLE -> RUN on start; RUN -> DONE when i==ITERATIONS-1; DONE -> IDLE unconditionally (1 cycle).
//  IDLE+start: latch x,y sign-extended to W+2 bits, z to W bits; i=0. start ignored while busy=1.
//  RUN, iteration i: d = (z>=0) ? +1 : -1
//    x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i]; i++ (all arithmetic shifts).
//  DONE: done=1; x_out/y_out = internal x/y saturated to [-2**(W-1), 2**(W-1)-1]; held until next DONE or reset.
//  Latency: start sampled at edge k -> done high in the cycle after edge k+ITERATIONS+1. Throughput one op per ITERATIONS+2 cycles.
//  start asserted in the DONE cycle is ignored; start in the cycle after done is accepted.
//  z outside +-pi/2: no error flag; result undefined. Internal z wraps (no saturation).
//  Reset mid-RUN: abort; no done pulse; outputs return to 0.
//  ATAN[i] = round(atan(2**-i)*8192): 6434,3798,2007,1019,511,256,128,64,32,16,8,4.
// STRUCTURE
//  Package cordic_pkg: Q2.13 format constants (ANGLE_FRAC=13, PI_2=12868, PI_4=6434), FSM state enum {IDLE,RUN,DONE}, ATAN table.
//  Sub-module cordic_atan_rom: combinational index -> ATAN[i] (W bits), indices >=12 return 0.
//  Shifts are inline >>> on W+2-bit values (sign-preserving); no logical shifter in this path.
// TESTING (compare with tolerance +-3 LSB unless noted)
//  1. x=1000,y=0,z=0 -> x_out~1647, y_out~0; done exactly 13 edges after start sampled.
//  2. x=1000,y=0,z=6434 (pi/4) -> x_out~1164, y_out~1164.
//  3. x=1000,y=0,z=-12868 (-pi/2) -> x_out~0, y_out~-1647.
//  4. x=30000,y=0,z=0 -> x_out=32767 exactly (saturation); x=-30000 -> x_out=-32768.
//  5. start held high continuously -> done pulses every 14 cycles; start pulses during busy do not change results.
//  6. rst asserted at iteration 5 -> next edge busy=0, done never pulses, x_out=y_out=0; fresh start then completes normally.

Source files
------------

// File: rtl/cordic_rotation_iter_pkg.sv
// Shared definitions for the rotation-mode CORDIC: Q2.13 angle constants,
// FSM state encoding and the arctangent table.
package cordic_pkg;

  localparam int ANGLE_FRAC = 13;
  localparam int PI_2       = 12868;
  localparam int PI_4       = 6434;
  localparam int ATAN_DEPTH = 12;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // round(atan(2**-i) * 2**ANGLE_FRAC); beyond the table depth the angle is negligible
  function automatic logic [15:0] atan_lookup(input int idx);
    case (idx)
      0:       atan_lookup = 16'd6434;
      1:       atan_lookup = 16'd3798;
      2:       atan_lookup = 16'd2007;
      3:       atan_lookup = 16'd1019;
      4:       atan_lookup = 16'd511;
      5:       atan_lookup = 16'd256;
      6:       atan_lookup = 16'd128;
      7:       atan_lookup = 16'd64;
      8:       atan_lookup = 16'd32;
      9:       atan_lookup = 16'd16;
      10:      atan_lookup = 16'd8;
      11:      atan_lookup = 16'd4;
      default: atan_lookup = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_rotation_iter_atan_rom.sv
// Combinational arctangent ROM: iteration index -> ATAN[i] in Q2.13.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH  = 16,
  parameter int SHIFT_LENGTH = 5
) (
  input  logic [SHIFT_LENGTH-1:0] idx,
  output logic [WORD_LENGTH-1:0]  atan
);

  always_comb atan = WORD_LENGTH'(atan_lookup(int'(idx)));

endmodule

// File: rtl/cordic_rotation_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, start/done
// handshake, outputs carry the uncompensated CORDIC gain and are saturated.
module cordic_rotation_iter
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH  = 16,
  parameter int SHIFT_LENGTH = 5,
  parameter int ITERATIONS   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] x_in,
  input  logic [WORD_LENGTH-1:0] y_in,
  input  logic [WORD_LENGTH-1:0] z_in,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] x_out,
  output logic [WORD_LENGTH-1:0] y_out
);

  // Two guard bits absorb the gain (~1.65) plus the sqrt(2) diagonal growth.
  localparam int XW = WORD_LENGTH + 2;

  state_t                   state;
  logic [SHIFT_LENGTH-1:0]  iter;
  logic signed [XW-1:0]     x_r, y_r, x_sh, y_sh, x_nxt, y_nxt;
  logic signed [WORD_LENGTH-1:0] z_r, z_nxt, atan_s;
  logic [WORD_LENGTH-1:0]   atan;

  cordic_atan_rom #(
    .WORD_LENGTH (WORD_LENGTH),
    .SHIFT_LENGTH(SHIFT_LENGTH)
  ) u_atan_rom (
    .idx (iter),
    .atan(atan)
  );

  always_comb begin
    x_sh   = x_r >>> iter;
    y_sh   = y_r >>> iter;
    atan_s = $signed(atan);
    if (!z_r[WORD_LENGTH-1]) begin
      x_nxt = x_r - y_sh;
      y_nxt = y_r + x_sh;
      z_nxt = z_r - atan_s;
    end else begin
      x_nxt = x_r + y_sh;
      y_nxt = y_r - x_sh;
      z_nxt = z_r + atan_s;
    end
  end

  // Clamp the guard-extended value: in range iff the top three bits agree.
  function automatic logic [WORD_LENGTH-1:0] sat(input logic signed [XW-1:0] v);
    if ((&v[XW-1:WORD_LENGTH-1]) || !(|v[XW-1:WORD_LENGTH-1]))
      sat = v[WORD_LENGTH-1:0];
    else if (v[XW-1])
      sat = {1'b1, {(WORD_LENGTH-1){1'b0}}};
    else
      sat = {1'b0, {(WORD_LENGTH-1){1'b1}}};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      iter  <= '0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      x_out <= '0;
      y_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_r   <= {{2{x_in[WORD_LENGTH-1]}}, x_in};
          y_r   <= {{2{y_in[WORD_LENGTH-1]}}, y_in};
          z_r   <= $signed(z_in);
          iter  <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          x_r  <= x_nxt;
          y_r  <= y_nxt;
          z_r  <= z_nxt;
          iter <= iter + 1'b1;
          if (iter == SHIFT_LENGTH'(ITERATIONS - 1)) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          x_out <= sat(x_r);
          y_out <= sat(y_r);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
